// File: rtl/seg_frame_decoder_pkg.sv
`default_nettype none
// ======================================================================
// seg_frame_decoder_pkg : segment patterns, blank code and FSM states
// Rev 1.0
// ======================================================================
package seg_frame_decoder_pkg;

    localparam int         c_num_digits = 6;
    localparam logic [3:0] c_blank_code = 4'hF;

    // Lit-high patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] c_seg_blank = 7'b0000000;
    localparam logic [6:0] c_seg_0     = 7'b0111111;
    localparam logic [6:0] c_seg_1     = 7'b0000110;
    localparam logic [6:0] c_seg_2     = 7'b1011011;
    localparam logic [6:0] c_seg_3     = 7'b1001111;
    localparam logic [6:0] c_seg_4     = 7'b1100110;
    localparam logic [6:0] c_seg_5     = 7'b1101101;
    localparam logic [6:0] c_seg_6     = 7'b1111101;
    localparam logic [6:0] c_seg_7     = 7'b0000111;
    localparam logic [6:0] c_seg_8     = 7'b1111111;
    localparam logic [6:0] c_seg_9     = 7'b1101111;

    typedef enum logic [0:0] {
        ST_TRACK = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = c_seg_0;
            4'd1:    seg = c_seg_1;
            4'd2:    seg = c_seg_2;
            4'd3:    seg = c_seg_3;
            4'd4:    seg = c_seg_4;
            4'd5:    seg = c_seg_5;
            4'd6:    seg = c_seg_6;
            4'd7:    seg = c_seg_7;
            4'd8:    seg = c_seg_8;
            4'd9:    seg = c_seg_9;
            default: seg = c_seg_blank;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_frame_decoder_if.sv
`default_nettype none
// ======================================================================
// seg_frame_decoder_if : segment inputs and decoded-frame handshake
// Rev 1.0
// ======================================================================
interface seg_frame_decoder_if;

    logic [6:0] J1, J2, J3, J4, J5, J6;
    logic       out_ready;
    logic [3:0] d1, d2, d3, d4, d5, d6;
    logic       out_valid;
    logic       overrun;
    logic [7:0] err_cnt;

    modport master (
        input  J1, J2, J3, J4, J5, J6, out_ready,
        output d1, d2, d3, d4, d5, d6, out_valid, overrun, err_cnt
    );

    modport slave (
        output J1, J2, J3, J4, J5, J6, out_ready,
        input  d1, d2, d3, d4, d5, d6, out_valid, overrun, err_cnt
    );

endinterface
`default_nettype wire

// File: rtl/seg_frame_decoder_seg7.sv
`default_nettype none
// ======================================================================
// seg7_to_bcd : one lit-high seven-segment pattern to digit code
// Rev 1.0
// ======================================================================
module seg7_to_bcd
    import seg_frame_decoder_pkg::*;
(
    input  wire logic [6:0] seg,
    output logic      [3:0] code,
    output logic            invalid
);

    always_comb begin
        code    = c_blank_code;
        invalid = 1'b0;
        case (seg)
            c_seg_blank: code = c_blank_code;
            c_seg_0:     code = 4'd0;
            c_seg_1:     code = 4'd1;
            c_seg_2:     code = 4'd2;
            c_seg_3:     code = 4'd3;
            c_seg_4:     code = 4'd4;
            c_seg_5:     code = 4'd5;
            c_seg_6:     code = 4'd6;
            c_seg_7:     code = 4'd7;
            c_seg_8:     code = 4'd8;
            c_seg_9:     code = 4'd9;
            default:     invalid = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_frame_decoder.sv
`default_nettype none
// ======================================================================
// seg_frame_decoder : debounced six-digit seven-segment frame decoder
// Rev 1.0
// ======================================================================
module seg_frame_decoder
    import seg_frame_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    seg_frame_decoder_if.master bus
);

    localparam logic [7:0] c_cnt_max = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] c_cnt_arm = 8'(STABLE_CYCLES - 2);

    logic [c_num_digits-1:0][6:0] w_raw;
    logic [c_num_digits-1:0][6:0] w_norm;
    logic [c_num_digits-1:0][6:0] r_sample;
    logic [c_num_digits-1:0][6:0] r_prev;
    logic [c_num_digits-1:0][3:0] w_code;
    logic [c_num_digits-1:0][3:0] r_d;
    logic [c_num_digits-1:0]      w_inv;
    logic [7:0]                   r_cnt;
    logic [7:0]                   r_err;
    logic                         r_overrun;
    logic                         w_same, w_stable, w_bad, w_new;
    logic                         w_load, w_drop;
    state_t                       r_state, w_state_nxt;

    assign w_raw  = {bus.J6, bus.J5, bus.J4, bus.J3, bus.J2, bus.J1};
    assign w_norm = SEG_ACTIVE_LOW ? ~w_raw : w_raw;

    for (genvar i = 0; i < c_num_digits; i++) begin : g_pos
        seg7_to_bcd u_dec (
            .seg     (r_sample[i]),
            .code    (w_code[i]),
            .invalid (w_inv[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sample <= '0;
            r_prev   <= '0;
            r_cnt    <= '0;
        end else begin
            r_sample <= w_norm;
            r_prev   <= r_sample;
            if (!w_same)
                r_cnt <= '0;
            else if (r_cnt != c_cnt_max)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    // Fires only on the edge where the counter steps onto its saturated value
    assign w_same   = (r_sample == r_prev);
    assign w_stable = w_same && (r_cnt == c_cnt_arm);
    assign w_bad    = w_stable && (|w_inv);
    assign w_new    = w_stable && !(|w_inv) && (w_code != r_d);

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= ST_TRACK;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_TRACK: begin
                if (w_new) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_new) begin
                    if (bus.out_ready)
                        w_load = 1'b1;
                    else
                        w_drop = 1'b1;
                end else if (bus.out_ready) begin
                    w_state_nxt = ST_TRACK;
                end
            end
            default: w_state_nxt = ST_TRACK;
        endcase
    end

    // r_d doubles as the last-emitted frame used for duplicate suppression
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_d       <= {c_num_digits{c_blank_code}};
            r_overrun <= 1'b0;
            r_err     <= '0;
        end else begin
            if (w_load)
                r_d <= w_code;
            if (w_drop)
                r_overrun <= 1'b1;
            if (w_bad && (r_err != 8'hFF))
                r_err <= r_err + 8'd1;
        end
    end

    assign bus.d1        = r_d[0];
    assign bus.d2        = r_d[1];
    assign bus.d3        = r_d[2];
    assign bus.d4        = r_d[3];
    assign bus.d5        = r_d[4];
    assign bus.d6        = r_d[5];
    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.overrun   = r_overrun;
    assign bus.err_cnt   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_frame_decoder.sv
`default_nettype none
// ======================================================================
// tb_seg_frame_decoder : directed self-checking bench for seg_frame_decoder
// Rev 1.0
// ======================================================================
module tb_seg_frame_decoder;

    logic        clk = 1'b0;
    logic        reset;
    int          n_checks = 0;
    int          n_err = 0;
    int          pulses;
    logic [7:0]  hi;
    logic [23:0] dframe;

    seg_frame_decoder_if bus ();

    seg_frame_decoder #(
        .STABLE_CYCLES  (4),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign dframe = {bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1};

    // Active-low pin pattern for a digit; 15 = all off, 20 = {ab} (invalid)
    function automatic logic [6:0] pat(input int dgt);
        logic [6:0] lit;
        case (dgt)
            0:       lit = 7'b0111111;
            1:       lit = 7'b0000110;
            2:       lit = 7'b1011011;
            3:       lit = 7'b1001111;
            4:       lit = 7'b1100110;
            5:       lit = 7'b1101101;
            6:       lit = 7'b1111101;
            7:       lit = 7'b0000111;
            8:       lit = 7'b1111111;
            9:       lit = 7'b1101111;
            20:      lit = 7'b0000011;
            default: lit = 7'b0000000;
        endcase
        return ~lit;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_count(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) pulses++;
        end
    endtask

    task automatic set_j(input int a, input int b, input int c,
                         input int e, input int f, input int g);
        bus.J1 = pat(a);
        bus.J2 = pat(b);
        bus.J3 = pat(c);
        bus.J4 = pat(e);
        bus.J5 = pat(f);
        bus.J6 = pat(g);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        reset         = 1'b0;
        bus.out_ready = 1'b0;
        set_j(15, 15, 15, 15, 15, 15);
        tick(2);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_frame", 32'(dframe), 32'hFFFFFF);
        chk("rst_overrun", 32'(bus.overrun), 32'h0);
        chk("rst_err", 32'(bus.err_cnt), 32'h0);
        reset = 1'b1;
        tick(6);
        chk("idle_blank_dup", 32'(bus.out_valid), 32'h0);

        // 12:34:56, one pulse five cycles after the change
        bus.out_ready = 1'b1;
        set_j(1, 2, 3, 4, 5, 6);
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (bus.out_valid) pulses++;
            if (i == 4) chk("t27_valid_c4", 32'(bus.out_valid), 32'h0);
            if (i == 5) begin
                chk("t27_valid_c5", 32'(bus.out_valid), 32'h1);
                chk("t27_frame", 32'(dframe), 32'h654321);
            end
        end
        chk("t27_pulses", 32'(pulses), 32'h1);

        // J1 toggling 1/7 every two cycles never settles
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            set_j((k % 2 == 0) ? 7 : 1, 2, 3, 4, 5, 6);
            tick_count(2);
        end
        tick_count(8);
        chk("t28_pulses", 32'(pulses), 32'h0);
        chk("t28_err", 32'(bus.err_cnt), 32'h0);

        // Invalid pattern on J3, then saturation of err_cnt
        pulses = 0;
        set_j(1, 2, 20, 4, 5, 6);
        tick_count(8);
        chk("t29_err_one", 32'(bus.err_cnt), 32'h1);
        for (int k = 0; k < 299; k++) begin
            set_j(1, 2, 3, 4, 5, 6);
            tick_count(6);
            set_j(1, 2, 20, 4, 5, 6);
            tick_count(6);
        end
        chk("t29_err_sat", 32'(bus.err_cnt), 32'hFF);
        set_j(1, 2, 3, 4, 5, 6);
        tick_count(6);
        chk("t29_pulses", 32'(pulses), 32'h0);
        chk("t29_err_hold", 32'(bus.err_cnt), 32'hFF);

        // Flashing J5/J6
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) set_j(1, 2, 3, 4, 5, 9);
            else            set_j(1, 2, 3, 4, 15, 15);
            pulses = 0;
            hi     = 8'h00;
            for (int i = 1; i <= 6; i++) begin
                tick(1);
                if (bus.out_valid) pulses++;
                if (i == 5) hi = dframe[23:16];
            end
            chk("t31_pulses", 32'(pulses), 32'h1);
            chk("t31_d65", 32'(hi), (k % 2 == 0) ? 32'h95 : 32'hFF);
        end

        // Acceptance coinciding with a new stable frame
        bus.out_ready = 1'b0;
        set_j(7, 8, 9, 0, 1, 2);
        tick(5);
        chk("t21_a_valid", 32'(bus.out_valid), 32'h1);
        chk("t21_a_frame", 32'(dframe), 32'h210987);
        set_j(3, 8, 9, 0, 1, 2);
        tick(4);
        chk("t21_a_held", 32'(dframe), 32'h210987);
        bus.out_ready = 1'b1;
        tick(1);
        chk("t21_b_valid", 32'(bus.out_valid), 32'h1);
        chk("t21_b_frame", 32'(dframe), 32'h210983);
        chk("t21_overrun", 32'(bus.overrun), 32'h0);
        tick(1);
        chk("t21_accept", 32'(bus.out_valid), 32'h0);

        // Overrun while waiting
        bus.out_ready = 1'b0;
        set_j(4, 8, 9, 0, 1, 2);
        tick(5);
        chk("t30_a_frame", 32'(dframe), 32'h210984);
        set_j(5, 8, 9, 0, 1, 2);
        tick(6);
        chk("t30_valid_held", 32'(bus.out_valid), 32'h1);
        chk("t30_frame_held", 32'(dframe), 32'h210984);
        chk("t30_overrun", 32'(bus.overrun), 32'h1);
        bus.out_ready = 1'b1;
        tick(1);
        chk("t30_accept", 32'(bus.out_valid), 32'h0);
        pulses = 0;
        tick_count(8);
        chk("t30_no_reemit", 32'(pulses), 32'h0);
        chk("t30_overrun_sticky", 32'(bus.overrun), 32'h1);
        set_j(6, 8, 9, 0, 1, 2);
        tick(5);
        chk("t30_c_frame", 32'(dframe), 32'h210986);
        bus.out_ready = 1'b0;
        tick(1);
        chk("t30_c_hold", 32'(bus.out_valid), 32'h1);

        // Reset during HOLD
        reset = 1'b0;
        tick(1);
        chk("t32_valid", 32'(bus.out_valid), 32'h0);
        chk("t32_frame", 32'(dframe), 32'hFFFFFF);
        chk("t32_overrun", 32'(bus.overrun), 32'h0);
        chk("t32_err", 32'(bus.err_cnt), 32'h0);
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            if (i == 4) chk("t32_settle_c4", 32'(bus.out_valid), 32'h0);
            if (i == 5) begin
                chk("t32_settle_c5", 32'(bus.out_valid), 32'h1);
                chk("t32_settle_frame", 32'(dframe), 32'h210986);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_frame_decoder.md
SEG_FRAME_DECODER -- requirements
Module: seg_frame_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, meaning: consecutive identical samples required before a frame is accepted (range 2..255).
REQ-002 Parameter SEG_ACTIVE_LOW, default 1, meaning: 1 = a lit segment reads 0 on J inputs.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 J1..J6  input  7 each  seven-segment buses, digit 1 (leftmost) to digit 6; bit0=a, bit1=b ... bit6=g.
REQ-006 out_ready  input  1  consumer accepts the presented frame when high with out_valid.
REQ-007 d1..d6  output  4 each  decoded digits, 0..9 or 4'hF for blank.
REQ-008 out_valid  output  1  a decoded frame is presented on d1..d6.
REQ-009 overrun  output  1  sticky: a new stable frame was dropped while out_valid was waiting.
REQ-010 err_cnt  output  8  saturating count of stable frames rejected for an invalid pattern.

Function
REQ-011 Each cycle the SHALL register the six J buses (after polarity normalisation to lit=1) as the current sample; one input register stage only.
REQ-012 Pattern decode SHALL map lit sets {abcdef}=0, {bc}=1, {abdeg}=2, {abcdg}=3, {bcfg}=4, {acdfg}=5, {acdefg}=6, {abc}=7, {abcdefg}=8, {abcdfg}=9, none lit=blank(4'hF); every other pattern is invalid.
REQ-013 A saturating stability counter SHALL reset to 0 when the current sample differs from the previous sample and increment otherwise, saturating at STABLE_CYCLES-1.
REQ-014 A frame SHALL become stable on the cycle the counter first reaches STABLE_CYCLES-1; it is then evaluated exactly once until the sample changes again.
REQ-015 A stable frame containing any invalid position SHALL not be emitted and SHALL increment err_cnt by 1, saturating at 255.
REQ-016 A stable valid frame identical to the last emitted frame SHALL be discarded silently (no emit, no error).
REQ-017 FSM states: TRACK (out_valid=0) and HOLD (out_valid=1).
REQ-018 TRACK -> HOLD: stable valid new frame; d1..d6 load its codes on the same edge, out_valid high the next cycle; latency from first changed J input to out_valid = STABLE_CYCLES+1 cycles.
REQ-019 HOLD -> TRACK: out_valid and out_ready both high at an edge; d1..d6 SHALL hold their value and stay stable throughout HOLD.
REQ-020 In HOLD, a stable valid new frame SHALL be dropped and overrun set to 1; tracking and stability counting continue in both states.
REQ-021 Simultaneous acceptance (out_ready high) and new stable frame in HOLD: the new frame SHALL load, out_valid stays high, overrun unchanged.
REQ-022 Blank digits (flashing display off phase) SHALL be emitted as 4'hF like any other valid frame.

Reset
REQ-023 While reset=0 at an edge: state=TRACK, out_valid=0, d1..d6=4'hF, overrun=0, err_cnt=0, stability counter=0, last-emitted frame=all blank, sample registers=all blank.
REQ-024 Reset asserted during HOLD SHALL discard the presented frame without a handshake; first frame after reset requires full STABLE_CYCLES settling.

Structure
REQ-025 Segment-pattern constants, blank code 4'hF, and the FSM state encoding SHALL live in a shared package used also by the segment encoder side.
REQ-026 Single-position decode SHALL be one sub-module seg7_to_bcd (7-bit lit pattern in, 4-bit code and invalid flag out), instantiated six times.

Verification
REQ-027 After reset, hold J = "12:34:56" patterns (active-low) for 10 cycles, out_ready=1 -> out_valid pulses once at cycle 5 with d1..d6 = 1,2,3,4,5,6.
REQ-028 Toggle J1 between "1" and "7" every 2 cycles with STABLE_CYCLES=4 -> no out_valid, err_cnt=0.
REQ-029 Hold J3 = pattern {ab} lit for 8 cycles -> no emit, err_cnt=1; repeat 300 such frames -> err_cnt=255.
REQ-030 out_ready=0, present frame A then stable frame B -> out_valid held with A, overrun=1; raise out_ready -> A accepted, B not re-emitted unless it changes.
REQ-031 Alternate J5/J6 between "5","9" and all-off every 6 cycles -> frames alternate d5,d6 = 5,9 and F,F.
REQ-032 Drive reset=0 for one cycle while in HOLD -> next cycle out_valid=0, d1..d6=F, overrun=0, err_cnt=0.
